// File: rtl/isa_pkg.sv
// ----------------------------------------------------------------------------
// isa_pkg
//
// Shared ISA definitions for the fetch stage and the control decoder.
//   - Default widths for the program counter, instruction word, opcode field,
//     branch-target LUT index and retired-instruction counter.
//   - The opcode occupies the top ISA_OPW bits of the instruction word; the
//     branch LUT index occupies the bottom ISA_LUT_W bits.
//   - OP_HALT: opcode that stops the program.
//   - state_t: fetch-stage control states.
// ----------------------------------------------------------------------------
package isa_pkg;

    localparam int ISA_PC_W    = 10;
    localparam int ISA_INSTR_W = 9;
    localparam int ISA_OPW     = 4;
    localparam int ISA_LUT_W   = 5;
    localparam int ISA_CNT_W   = 16;

    localparam logic [ISA_OPW-1:0] OP_HALT = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

endpackage

// File: rtl/branch_lut.sv
// ----------------------------------------------------------------------------
// branch_lut
//
// Combinational branch-target table. A taken branch carries a short LUT index
// in its low bits instead of a full address; this table expands that index
// into an absolute PC. Programs retarget branches by editing this table only.
//
// Ports:
//   idx    : in,  LUT_W bits - index taken from the branch instruction
//   target : out, PC_W bits  - absolute branch target address
// ----------------------------------------------------------------------------
module branch_lut
    import isa_pkg::*;
#(
    parameter int PC_W  = ISA_PC_W,
    parameter int LUT_W = ISA_LUT_W
) (
    input  logic [LUT_W-1:0] idx,
    output logic [PC_W-1:0]  target
);

    // Explicit entries for the hand-placed targets; every other index maps
    // to a 16-word aligned slot so unused entries still land somewhere sane.
    always_comb begin
        target = PC_W'({idx, 4'b0000});
        case (idx)
            LUT_W'(0): target = PC_W'(10'h000);
            LUT_W'(1): target = PC_W'(10'h010);
            LUT_W'(2): target = PC_W'(10'h020);
            LUT_W'(3): target = PC_W'(10'h040);
            LUT_W'(4): target = PC_W'(10'h080);
            LUT_W'(5): target = PC_W'(10'h100);
            LUT_W'(6): target = PC_W'(10'h200);
            LUT_W'(7): target = PC_W'(10'h3F0);
            default:   target = PC_W'({idx, 4'b0000});
        endcase
    end

endmodule

// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch stage feeding the control decoder. Owns the program
// counter, registers the fetched word into the instruction register (IR),
// resolves taken branches through branch_lut (squashing the wrong-path fetch
// with a one-cycle bubble), detects HALT and counts retired instructions.
//
// Ports:
//   clk         : in,  1       - clock, rising edge
//   rst_n       : in,  1       - asynchronous active-low reset
//   start       : in,  1       - begin (or restart) execution from PC 0
//   stall       : in,  1       - freeze PC, IR and counter this cycle
//   branch      : in,  1       - decoder Branch for the current IR
//   br_cond     : in,  1       - datapath condition; taken = branch & br_cond
//   imem_addr   : out, PC_W    - instruction memory address (pc register)
//   imem_data   : in,  INSTR_W - combinational read data at imem_addr
//   instr       : out, INSTR_W - IR contents
//   instr_pc    : out, PC_W    - PC of the instruction in the IR
//   instr_valid : out, 1       - IR holds a live instruction
//   done        : out, 1       - program halted
//   retired     : out, CNT_W   - saturating count of instructions leaving IR
// ----------------------------------------------------------------------------
module instr_fetch
    import isa_pkg::*;
#(
    parameter int PC_W    = ISA_PC_W,
    parameter int INSTR_W = ISA_INSTR_W,
    parameter int OPW     = ISA_OPW,
    parameter int LUT_W   = ISA_LUT_W,
    parameter int CNT_W   = ISA_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stall,
    input  logic               branch,
    input  logic               br_cond,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    output logic               done,
    output logic [CNT_W-1:0]   retired
);

    state_t             state_q,       state_d;
    logic [PC_W-1:0]    pc_q,          pc_d;
    logic [INSTR_W-1:0] instr_q,       instr_d;
    logic [PC_W-1:0]    instr_pc_q,    instr_pc_d;
    logic               instr_valid_q, instr_valid_d;
    logic               done_q,        done_d;
    logic [CNT_W-1:0]   retired_q,     retired_d;

    logic [OPW-1:0]     opcode;
    logic [PC_W-1:0]    br_target;
    logic               is_halt;
    logic               br_taken;

    // Counter sticks at all-ones rather than wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    branch_lut #(
        .PC_W  (PC_W),
        .LUT_W (LUT_W)
    ) u_branch_lut (
        .idx    (instr_q[LUT_W-1:0]),
        .target (br_target)
    );

    // Decoder inputs only matter while the IR holds a live instruction.
    assign opcode   = instr_q[INSTR_W-1 -: OPW];
    assign is_halt  = instr_valid_q && (opcode == OPW'(OP_HALT));
    assign br_taken = instr_valid_q && branch && br_cond;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        done_d        = done_q;
        retired_d     = retired_q;

        case (state_q)
            IDLE: begin
                instr_valid_d = 1'b0;
                if (start) begin
                    pc_d      = '0;
                    retired_d = '0;
                    state_d   = RUN;
                end
            end

            RUN: begin
                // Priority: stall, then halt, then taken branch, then fetch.
                if (stall) begin
                    state_d = RUN;
                end else if (is_halt) begin
                    state_d       = HALT;
                    instr_valid_d = 1'b0;
                    done_d        = 1'b1;
                    retired_d     = sat_inc(retired_q);
                end else if (br_taken) begin
                    // The word at pc_q is the wrong path; skip loading it.
                    pc_d          = br_target;
                    instr_valid_d = 1'b0;
                    retired_d     = sat_inc(retired_q);
                end else begin
                    instr_d       = imem_data;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    pc_d          = pc_q + 1'b1;
                    if (instr_valid_q) begin
                        retired_d = sat_inc(retired_q);
                    end
                end
            end

            HALT: begin
                done_d        = 1'b1;
                instr_valid_d = 1'b0;
                if (start) begin
                    done_d    = 1'b0;
                    pc_d      = '0;
                    retired_d = '0;
                    state_d   = RUN;
                end
            end

            default: begin
                state_d       = IDLE;
                instr_valid_d = 1'b0;
                done_d        = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            done_q        <= 1'b0;
            retired_q     <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            done_q        <= done_d;
            retired_q     <= retired_d;
        end
    end

    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign done        = done_q;
    assign retired     = retired_q;

endmodule
